// File: rtl/uart_pkg.sv
// Shared UART types and constants.
// Used by the receiver and the baud generator.
package uart_pkg;

  localparam int UART_OVERSAMPLE  = 16;
  localparam int UART_SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_rx_state_t;

endpackage

// File: rtl/uart_baud_gen.sv
// Oversample tick generator: one tick every clk_divider+1 clocks.
// The divider is captured on clear so a mid-frame change waits for the next frame.
module uart_baud_gen
  import uart_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic [7:0] clk_divider,
  output logic       tick
);

  logic [7:0] cnt_q, cnt_d;
  logic [7:0] lat_q, lat_d;
  logic       wrap;

  assign wrap = (cnt_q == lat_q);
  assign tick = wrap & ~clear;

  always_comb begin
    cnt_d = cnt_q;
    lat_d = lat_q;
    if (clear) begin
      cnt_d = 8'd0;
      lat_d = clk_divider;
    end else if (wrap) begin
      cnt_d = 8'd0;
    end else begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= 8'd0;
      lat_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
      lat_q <= lat_d;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with 16x oversampling and framing-error detect.
// Each byte or error is reported as a single-cycle pulse.
module uart_rx
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE  = UART_OVERSAMPLE,
  parameter int SYNC_STAGES = UART_SYNC_STAGES
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] clk_divider,
  input  logic       sin,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_err,
  output logic       rx_busy
);

  localparam int OSW = $clog2(OVERSAMPLE);
  localparam logic [OSW-1:0] OS_MID  = OSW'(OVERSAMPLE/2 - 1);
  localparam logic [OSW-1:0] OS_LAST = OSW'(OVERSAMPLE - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sin_s;
  logic                   sin_q;
  logic                   fall;

  uart_rx_state_t state_q, state_d;
  logic [OSW-1:0] os_q, os_d;
  logic [2:0]     bit_q, bit_d;
  logic [7:0]     sh_q, sh_d;
  logic [7:0]     data_q, data_d;
  logic           valid_q, valid_d;
  logic           err_q, err_d;
  logic           clear;
  logic           tick;

  assign sin_s = sync_q[SYNC_STAGES-1];
  assign fall  = sin_q & ~sin_s;

  uart_baud_gen u_baud (
    .clk         (clk),
    .rst         (rst),
    .clear       (clear),
    .clk_divider (clk_divider),
    .tick        (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '1;
      sin_q  <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sin};
      sin_q  <= sin_s;
    end
  end

  always_comb begin
    state_d = state_q;
    os_d    = os_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    data_d  = data_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    clear   = 1'b0;
    if (!en) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (fall) begin
            clear   = 1'b1;
            os_d    = '0;
            state_d = START;
          end
        end
        START: begin
          if (tick) begin
            if (os_q == OS_MID) begin
              if (!sin_s) begin
                os_d    = '0;
                bit_d   = 3'd0;
                state_d = DATA;
              end else begin
                state_d = IDLE;
              end
            end else begin
              os_d = os_q + OSW'(1);
            end
          end
        end
        DATA: begin
          if (tick) begin
            os_d = os_q + OSW'(1);
            if (os_q == OS_LAST) begin
              sh_d  = {sin_s, sh_q[7:1]};
              bit_d = bit_q + 3'd1;
              if (bit_q == 3'd7) state_d = STOP;
            end
          end
        end
        STOP: begin
          if (tick) begin
            os_d = os_q + OSW'(1);
            if (os_q == OS_LAST) begin
              if (sin_s) begin
                data_d  = sh_q;
                valid_d = 1'b1;
              end else begin
                err_d = 1'b1;
              end
              state_d = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      os_q    <= '0;
      bit_q   <= 3'd0;
      sh_q    <= 8'h00;
      data_q  <= 8'h00;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      os_q    <= os_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign rx_data  = data_q;
  assign rx_valid = valid_q;
  assign rx_err   = err_q;
  assign rx_busy  = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx.
// Frames are driven bit by bit; expected pulses are queued at send time.
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [7:0] clk_divider;
  logic       sin;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_err;
  logic       rx_busy;

  uart_rx dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .clk_divider (clk_divider),
    .sin         (sin),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_err      (rx_err),
    .rx_busy     (rx_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         err;
    logic [7:0] data;
  } ev_t;

  ev_t         sb[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int unsigned cyc = 0;
  int unsigned last_valid_cyc = 0;
  int unsigned prev_valid_cyc = 0;
  int unsigned frame_t0 = 0;
  logic [7:0]  last_good = 8'h00;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin : mon
    ev_t e;
    if (!rst && (rx_valid || rx_err)) begin
      check("excl", 32'(rx_valid & rx_err), 32'd0);
      if (rx_valid) begin
        prev_valid_cyc = last_valid_cyc;
        last_valid_cyc = cyc;
      end
      if (sb.size() == 0) begin
        check("unexp_pulse", 32'({rx_valid, rx_err}), 32'd0);
      end else begin
        e = sb.pop_front();
        check("kind_err", 32'(rx_err), 32'(e.err));
        check("data", 32'(rx_data), 32'(e.data));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic hold(input logic v, input int n);
    sin = v;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input bit stop,
                            input int dv, input bit push);
    int bp;
    ev_t e;
    bp = 16 * (dv + 1);
    if (push) begin
      e.err  = !stop;
      e.data = stop ? d : last_good;
      if (stop) last_good = d;
      sb.push_back(e);
    end
    frame_t0 = cyc;
    hold(1'b0, bp);
    for (int i = 0; i < 8; i++) hold(d[i], bp);
    hold(stop, bp);
    sin = 1'b1;
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (sb.size() != 0) begin
      check("drain_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
  endtask

  function automatic bit lat_ok(input int unsigned lat, input int dv);
    int base;
    base = 152 * (dv + 1);
    return (lat >= base + 2) && (lat <= base + 5);
  endfunction

  initial begin
    int busy;
    int unsigned t;
    rst = 1'b1;
    en = 1'b0;
    clk_divider = 8'd0;
    sin = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_data", 32'(rx_data), 32'h00);
    check("rst_valid", 32'(rx_valid), 32'd0);
    check("rst_err", 32'(rx_err), 32'd0);
    check("rst_busy", 32'(rx_busy), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    en = 1'b1;

    // D=0 single frame with latency
    hold(1'b1, 20);
    send_frame(8'h55, 1'b1, 0, 1'b1);
    t = frame_t0;
    wait_drain(400);
    check("lat_d0", 32'(lat_ok(last_valid_cyc - t, 0)), 32'd1);
    @(negedge clk);
    check("valid_low", 32'(rx_valid), 32'd0);
    @(posedge clk);
    #1;

    // D=3 back-to-back
    clk_divider = 8'd3;
    hold(1'b1, 20);
    send_frame(8'hA5, 1'b1, 3, 1'b1);
    send_frame(8'h3C, 1'b1, 3, 1'b1);
    wait_drain(1600);
    t = last_valid_cyc - prev_valid_cyc;
    check("b2b_gap", 32'(t >= 636 && t <= 644), 32'd1);

    // framing error then good frame
    clk_divider = 8'd0;
    hold(1'b1, 20);
    send_frame(8'hFF, 1'b0, 0, 1'b1);
    hold(1'b1, 20);
    wait_drain(400);
    check("err_keep", 32'(rx_data), 32'h3C);
    send_frame(8'h12, 1'b1, 0, 1'b1);
    wait_drain(400);

    // glitch, then stuck-low line
    hold(1'b1, 20);
    sin = 1'b0;
    hold(1'b0, 4);
    sin = 1'b1;
    busy = 0;
    repeat (40) begin
      @(negedge clk);
      if (rx_busy) busy++;
    end
    @(posedge clk);
    #1;
    check("glitch_busy", 32'(busy >= 1 && busy <= 12), 32'd1);
    begin
      ev_t e;
      e.err = 1'b1;
      e.data = last_good;
      sb.push_back(e);
    end
    hold(1'b0, 320);
    hold(1'b1, 40);
    wait_drain(400);
    check("stuck_idle", 32'(rx_busy), 32'd0);

    // D=1 abort mid-DATA
    clk_divider = 8'd1;
    hold(1'b1, 40);
    fork
      send_frame(8'h81, 1'b1, 1, 1'b0);
      begin
        repeat (128) @(posedge clk);
        #1;
        check("busy_mid", 32'(rx_busy), 32'd1);
        en = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("abort_busy", 32'(rx_busy), 32'd0);
      end
    join
    hold(1'b1, 20);
    check("abort_keep", 32'(rx_data), 32'h12);
    en = 1'b1;
    hold(1'b1, 20);
    send_frame(8'h81, 1'b1, 1, 1'b1);
    wait_drain(800);

    // divider change mid-frame
    clk_divider = 8'd0;
    hold(1'b1, 20);
    fork
      send_frame(8'h42, 1'b1, 0, 1'b1);
      begin
        repeat (50) @(posedge clk);
        #1;
        clk_divider = 8'd7;
      end
    join
    t = frame_t0;
    wait_drain(400);
    check("lat_cdr_old", 32'(lat_ok(last_valid_cyc - t, 0)), 32'd1);
    hold(1'b1, 20);
    send_frame(8'hC3, 1'b1, 7, 1'b1);
    t = frame_t0;
    wait_drain(3200);
    check("lat_cdr_new", 32'(lat_ok(last_valid_cyc - t, 7)), 32'd1);

    hold(1'b1, 20);
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
